// File: rtl/pixel_stream_proc.sv
// Streaming pixel processor: bypass / invert / signed 3x3 convolution / threshold,
// selected per frame, with a single registered valid/ready output stage.
module pixel_stream_proc #(
    parameter int PW    = 8,
    parameter int IMG_W = 8,
    parameter int KW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PW-1:0]   pixel_in,
    input  logic            sof_in,
    input  logic            valid_in,
    output logic            ready_in,
    output logic [PW-1:0]   pixel_out,
    output logic            valid_out,
    input  logic            ready_out,
    input  logic [1:0]      mode,
    input  logic [9*KW-1:0] kernel,
    input  logic [4:0]      shift,
    input  logic [PW-1:0]   thresh,
    output logic [31:0]     status
);

    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ACC_W = PW + KW + 5;
    localparam int PR_W  = PW + KW + 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PW) - 1);

    localparam logic [1:0] M_BYPASS = 2'b00;
    localparam logic [1:0] M_INVERT = 2'b01;
    localparam logic [1:0] M_CONV   = 2'b10;

    // Clamp a signed convolution result into the unsigned pixel range.
    function automatic logic [PW-1:0] sat_pix(input logic signed [ACC_W-1:0] v);
        if (v[ACC_W-1])
            return '0;
        else if (v > PIX_MAX)
            return '1;
        else
            return v[PW-1:0];
    endfunction

    // Control state
    logic [CW-1:0]    col_q;
    logic [1:0]       row_q;
    logic [1:0]       mode_q;
    logic [9*KW-1:0]  kernel_q;
    logic [4:0]       shift_q;
    logic [PW-1:0]    thresh_q;
    logic             valid_out_q;
    logic [PW-1:0]    pixel_out_q;
    logic [15:0]      frame_cnt_q;
    logic [15:0]      out_cnt_q;
    logic             seen_sof_q;

    // Data state: two previous lines plus the two older window columns
    logic [PW-1:0]    lb0_q [IMG_W];
    logic [PW-1:0]    lb1_q [IMG_W];
    logic [PW-1:0]    win_q [3][2];

    logic             accept;
    logic [1:0]       mode_e;
    logic [9*KW-1:0]  kern_e;
    logic [4:0]       shift_e;
    logic [PW-1:0]    thresh_e;
    logic [CW-1:0]    col_c, col_d;
    logic [1:0]       row_c, row_d;
    logic [PW-1:0]    newcol [3];
    logic [PW-1:0]    tap [9];
    logic signed [PR_W-1:0]  pix_x, coef_x, prod;
    logic signed [ACC_W-1:0] acc, acc_sh;
    logic             out_en;
    logic [PW-1:0]    result;

    assign ready_in  = !valid_out_q || ready_out;
    assign accept    = valid_in && ready_in;
    assign valid_out = valid_out_q;
    assign pixel_out = pixel_out_q;
    assign status    = {frame_cnt_q, out_cnt_q};

    // A sof pixel is processed with the settings it brings in, at position (0,0).
    always_comb begin
        mode_e   = sof_in ? mode   : mode_q;
        kern_e   = sof_in ? kernel : kernel_q;
        shift_e  = sof_in ? shift  : shift_q;
        thresh_e = sof_in ? thresh : thresh_q;
        col_c    = sof_in ? '0 : col_q;
        row_c    = sof_in ? '0 : row_q;
        col_d    = col_c + CW'(1);
        row_d    = row_c;
        if (col_c == COL_LAST) begin
            col_d = '0;
            row_d = (row_c == 2'd2) ? 2'd2 : row_c + 2'd1;
        end
    end

    always_comb begin
        newcol[0] = lb1_q[col_c];
        newcol[1] = lb0_q[col_c];
        newcol[2] = pixel_in;
        for (int r = 0; r < 3; r++) begin
            tap[r*3+0] = win_q[r][0];
            tap[r*3+1] = win_q[r][1];
            tap[r*3+2] = newcol[r];
        end
    end

    // Pixels are zero-extended, coefficients sign-extended, to a common product width.
    always_comb begin
        acc    = '0;
        pix_x  = '0;
        coef_x = '0;
        prod   = '0;
        for (int i = 0; i < 9; i++) begin
            pix_x  = $signed({{KW{1'b0}}, tap[i], 1'b0}) >>> 1;
            coef_x = $signed({{(PW+1){kern_e[(8-i)*KW+KW-1]}}, kern_e[(8-i)*KW +: KW]});
            prod   = pix_x * coef_x;
            acc    = acc + $signed({{(ACC_W-PR_W){prod[PR_W-1]}}, prod});
        end
        acc_sh = acc >>> shift_e;
    end

    always_comb begin
        out_en = accept;
        result = pixel_in;
        case (mode_e)
            M_BYPASS: result = pixel_in;
            M_INVERT: result = ~pixel_in;
            M_CONV: begin
                result = sat_pix(acc_sh);
                out_en = accept && (row_c == 2'd2) && (col_c >= CW'(2));
            end
            default:  result = (pixel_in >= thresh_e) ? '1 : '0;
        endcase
    end

    // Output stage / control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= M_BYPASS;
            kernel_q    <= '0;
            shift_q     <= '0;
            thresh_q    <= '0;
            valid_out_q <= 1'b0;
            pixel_out_q <= '0;
            frame_cnt_q <= '0;
            out_cnt_q   <= '0;
            seen_sof_q  <= 1'b0;
        end else begin
            if (accept) begin
                col_q <= col_d;
                row_q <= row_d;
                if (sof_in) begin
                    mode_q     <= mode;
                    kernel_q   <= kernel;
                    shift_q    <= shift;
                    thresh_q   <= thresh;
                    seen_sof_q <= 1'b1;
                    if (seen_sof_q)
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                end
            end
            if (out_en) begin
                valid_out_q <= 1'b1;
                pixel_out_q <= result;
            end else if (ready_out) begin
                valid_out_q <= 1'b0;
            end
            // A transfer coinciding with a new sof belongs to the previous frame.
            if (accept && sof_in)
                out_cnt_q <= '0;
            else if (valid_out_q && ready_out)
                out_cnt_q <= out_cnt_q + 16'd1;
        end
    end

    // Line buffers and window
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= newcol[r];
            end
            lb1_q[col_c] <= lb0_q[col_c];
            lb0_q[col_c] <= pixel_in;
        end
    end

endmodule

// File: tb/tb_pixel_stream_proc.sv
// Directed bench for pixel_stream_proc (PW=8, IMG_W=8, KW=8).
module tb_pixel_stream_proc;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pixel_in;
    logic        sof_in;
    logic        valid_in;
    logic        ready_in;
    logic [7:0]  pixel_out;
    logic        valid_out;
    logic        ready_out;
    logic [1:0]  mode;
    logic [71:0] kernel;
    logic [4:0]  shift;
    logic [7:0]  thresh;
    logic [31:0] status;

    int vectors     = 0;
    int miscompares = 0;
    int nout;

    localparam logic [71:0] K_ONES   = {9{8'h01}};
    localparam logic [71:0] K_CENTER = {8'h00, 8'h00, 8'h00, 8'h00, 8'hFF,
                                        8'h00, 8'h00, 8'h00, 8'h00};

    pixel_stream_proc #(.PW(8), .IMG_W(8), .KW(8)) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .sof_in(sof_in),
        .valid_in(valid_in), .ready_in(ready_in), .pixel_out(pixel_out),
        .valid_out(valid_out), .ready_out(ready_out), .mode(mode),
        .kernel(kernel), .shift(shift), .thresh(thresh), .status(status)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] p, input logic s);
        valid_in = v;
        pixel_in = p;
        sof_in   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic send_chk(input string tag, input logic [7:0] p, input logic s,
                            input logic ev, input logic [7:0] ep);
        step(1'b1, p, s);
        chk({tag, " valid"}, {31'd0, valid_out}, {31'd0, ev});
        if (ev)
            chk({tag, " data"}, {24'd0, pixel_out}, {24'd0, ep});
    endtask

    task automatic idle_chk(input string tag);
        step(1'b0, 8'd0, 1'b0);
        chk({tag, " drained"}, {31'd0, valid_out}, 32'd0);
    endtask

    // Ramp 0..n-1 through a blur kernel; centre (r-1,c-1) has value 8(r-1)+(c-1),
    // so a 3x3 all-ones sum is nine times that, then shifted and clamped.
    task automatic conv_ramp(input string tag, input int sh, input int n,
                             input int stall_at, output int cnt);
        int r, c, ep, last_ep;
        logic ev;
        cnt = 0;
        last_ep = 0;
        for (int i = 0; i < n; i++) begin
            r = i / 8;
            c = i % 8;
            if (i == stall_at) begin
                ready_out = 1'b0;
                valid_in  = 1'b1;
                pixel_in  = 8'(i);
                sof_in    = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk);
                    #1;
                    chk($sformatf("%s stall%0d ready_in", tag, k), {31'd0, ready_in}, 32'd0);
                    chk($sformatf("%s stall%0d valid", tag, k), {31'd0, valid_out}, 32'd1);
                    chk($sformatf("%s stall%0d data", tag, k), {24'd0, pixel_out}, 32'(last_ep));
                end
                ready_out = 1'b1;
            end
            ev = (r >= 2) && (c >= 2);
            ep = (9 * (8 * (r - 1) + (c - 1))) >> sh;
            if (ep > 255) ep = 255;
            send_chk($sformatf("%s px%0d", tag, i), 8'(i), i == 0, ev, 8'(ep));
            if (ev) begin
                cnt++;
                last_ep = ep;
            end
        end
    endtask

    initial begin
        rst = 1'b1; pixel_in = '0; sof_in = 0; valid_in = 0; ready_out = 1'b1;
        mode = 2'b00; kernel = '0; shift = '0; thresh = '0;

        // Reset state
        step(1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        chk("reset valid_out", {31'd0, valid_out}, 32'd0);
        chk("reset pixel_out", {24'd0, pixel_out}, 32'd0);
        chk("reset status", status, 32'd0);
        chk("reset ready_in", {31'd0, ready_in}, 32'd1);
        rst = 1'b0;

        // Bypass
        mode = 2'b00;
        for (int i = 0; i < 20; i++)
            send_chk($sformatf("bypass px%0d", i), 8'(i), i == 0, 1'b1, 8'(i));
        idle_chk("bypass");
        chk("bypass status", status, 32'd20);

        // Invert, with a mode change mid-frame that must be ignored
        mode = 2'b01;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) mode = 2'b00;
            send_chk($sformatf("invert px%0d", i), 8'(i), i == 0, 1'b1, 8'(255 - i));
        end
        idle_chk("invert");
        chk("invert status", status, {16'd1, 16'd20});

        // Convolution blur, shift 0 then shift 3
        mode = 2'b10; kernel = K_ONES; shift = 5'd0;
        conv_ramp("blur0", 0, 64, -1, nout);
        chk("blur0 count", 32'(nout), 32'd36);
        idle_chk("blur0");
        chk("blur0 status", status, {16'd2, 16'd36});

        shift = 5'd3;
        conv_ramp("blur3", 3, 64, -1, nout);
        chk("blur3 count", 32'(nout), 32'd36);
        idle_chk("blur3");

        // Saturation high and low
        shift = 5'd0; kernel = K_ONES;
        for (int i = 0; i < 24; i++)
            send_chk($sformatf("sathi px%0d", i), 8'd255, i == 0,
                     (i / 8 >= 2) && (i % 8 >= 2), 8'd255);
        idle_chk("sathi");
        kernel = K_CENTER;
        for (int i = 0; i < 24; i++)
            send_chk($sformatf("satlo px%0d", i), 8'd255, i == 0,
                     (i / 8 >= 2) && (i % 8 >= 2), 8'd0);
        idle_chk("satlo");

        // Threshold
        mode = 2'b11; thresh = 8'd10;
        send_chk("thr 8", 8'd8, 1'b1, 1'b1, 8'd0);
        send_chk("thr 9", 8'd9, 1'b0, 1'b1, 8'd0);
        send_chk("thr 10", 8'd10, 1'b0, 1'b1, 8'd255);
        send_chk("thr 11", 8'd11, 1'b0, 1'b1, 8'd255);
        send_chk("thr 12", 8'd12, 1'b0, 1'b1, 8'd255);
        idle_chk("thr");
        chk("thr status", status, {16'd6, 16'd5});

        // Backpressure mid-frame
        mode = 2'b10; kernel = K_ONES; shift = 5'd0;
        conv_ramp("stall", 0, 64, 21, nout);
        chk("stall count", 32'(nout), 32'd36);
        idle_chk("stall");

        // Reset mid-frame, then a clean frame
        conv_ramp("prerst", 0, 21, -1, nout);
        rst = 1'b1;
        step(1'b0, 8'd0, 1'b0);
        chk("midrst valid_out", {31'd0, valid_out}, 32'd0);
        chk("midrst status", status, 32'd0);
        rst = 1'b0;
        conv_ramp("postrst", 0, 64, -1, nout);
        chk("postrst count", 32'(nout), 32'd36);
        idle_chk("postrst");
        chk("postrst status", status, {16'd0, 16'd36});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
